// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine controller.
package vend_pkg;

    // Controller modes: accepting credit, paying change, refunding credit.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VEND_CHG = 2'd1,
        REFUND   = 2'd2
    } state_t;

    // Coin values in cents.
    localparam logic [8:0] C5  = 9'd5;
    localparam logic [8:0] C10 = 9'd10;
    localparam logic [8:0] C25 = 9'd25;

    // Coin choice produced by the change selector.
    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_C5   = 2'd1,
        COIN_C10  = 2'd2,
        COIN_C25  = 2'd3
    } coin_t;

    // Value in cents of a selected coin (zero when nothing is selected).
    function automatic logic [8:0] coin_value(input coin_t c);
        logic [8:0] v;
        v = 9'd0;
        case (c)
            COIN_C5:  v = C5;
            COIN_C10: v = C10;
            COIN_C25: v = C25;
            default:  v = 9'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_if.sv
// Bus between the vending controller and its coin mechanism / host.
//
// Handshake: there is no valid/ready pairing on this bus. Every input is
// sampled on each rising clock edge: detect_X and buy/return_coins are
// single-cycle pulses, amount is meaningful whenever buy is high, and
// empty_X are levels. Every output is registered; ok and return_X are
// single-cycle pulses (one high cycle per event / per coin), total and busy
// are levels.
interface vend_if;
    logic       detect_5;
    logic       detect_10;
    logic       detect_25;
    logic       buy;
    logic       return_coins;
    logic [8:0] amount;
    logic       empty_5;
    logic       empty_10;
    logic       empty_25;
    logic       ok;
    logic       return_5;
    logic       return_10;
    logic       return_25;
    logic [8:0] total;
    logic       busy;

    // Host / coin-mechanism side.
    modport master (
        output detect_5, detect_10, detect_25, buy, return_coins, amount,
               empty_5, empty_10, empty_25,
        input  ok, return_5, return_10, return_25, total, busy
    );

    // Controller side.
    modport slave (
        input  detect_5, detect_10, detect_25, buy, return_coins, amount,
               empty_5, empty_10, empty_25,
        output ok, return_5, return_10, return_25, total, busy
    );

    // Test driver side, same direction as the host.
    modport TB (
        output detect_5, detect_10, detect_25, buy, return_coins, amount,
               empty_5, empty_10, empty_25,
        input  ok, return_5, return_10, return_25, total, busy
    );

    // Passive observers of the whole bus.
    modport MONITOR (
        input detect_5, detect_10, detect_25, buy, return_coins, amount,
              empty_5, empty_10, empty_25,
              ok, return_5, return_10, return_25, total, busy
    );

    modport DUT_MON (
        input detect_5, detect_10, detect_25, buy, return_coins, amount,
              empty_5, empty_10, empty_25,
              ok, return_5, return_10, return_25, total, busy
    );

endinterface

// File: rtl/vend_change_sel.sv
// Greedy coin selector used while paying change or refunding credit.
// Picks the largest coin that fits in total and whose tube is not empty.
// If that coin's return line is already busy with a bounce this cycle,
// nothing is dispensed (the dispenser waits a cycle rather than
// substituting a smaller coin).
module vend_change_sel
    import vend_pkg::*;
(
    input  logic [8:0] total,
    input  logic       empty_5,
    input  logic       empty_10,
    input  logic       empty_25,
    input  logic [2:0] bounce_mask,   // {25, 10, 5}
    output coin_t      coin
);

    coin_t greedy;

    // Greedy pick, then veto it if its line carries a bounce this cycle.
    always_comb begin
        greedy = COIN_NONE;
        if (total >= C25 && !empty_25) begin
            greedy = COIN_C25;
        end else if (total >= C10 && !empty_10) begin
            greedy = COIN_C10;
        end else if (total >= C5 && !empty_5) begin
            greedy = COIN_C5;
        end

        coin = greedy;
        case (greedy)
            COIN_C25: if (bounce_mask[2]) coin = COIN_NONE;
            COIN_C10: if (bounce_mask[1]) coin = COIN_NONE;
            COIN_C5:  if (bounce_mask[0]) coin = COIN_NONE;
            default:  coin = COIN_NONE;
        endcase
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine controller: credit accumulation, sale acceptance,
// coin bouncing and change/refund sequencing. All outputs are registered.
// MAX_CREDIT must be <= 511 and a multiple of 5.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned MAX_CREDIT = 500
) (
    input  logic   clk,
    input  logic   rst,        // asynchronous, active low
    vend_if.slave  bus,
    output state_t dbg_state
);

    localparam logic [9:0] MAX_CREDIT_W = 10'(MAX_CREDIT);

    state_t     state_q, state_d;
    logic [8:0] total_q, total_d;
    logic       ok_q, ok_d;
    logic       ret5_q, ret5_d;
    logic       ret10_q, ret10_d;
    logic       ret25_q, ret25_d;
    logic       busy_q, busy_d;

    logic [2:0] detect_vec;
    logic [9:0] coin_add;
    logic [9:0] credit_sum;
    logic [8:0] base;
    logic       sale;
    logic       refund_req;
    logic       credit_ok;
    logic [2:0] bounce;
    logic [2:0] disp;
    coin_t      sel;

    assign detect_vec = {bus.detect_25, bus.detect_10, bus.detect_5};

    // Value of all coins detected this cycle (10 bits so the ceiling check cannot wrap).
    always_comb begin
        coin_add = 10'd0;
        if (bus.detect_5)  coin_add = coin_add + 10'(C5);
        if (bus.detect_10) coin_add = coin_add + 10'(C10);
        if (bus.detect_25) coin_add = coin_add + 10'(C25);
    end

    // Sale/refund decisions and coin crediting; the sale is judged on the old credit.
    always_comb begin
        sale       = 1'b0;
        refund_req = 1'b0;
        base       = total_q;
        credit_sum = {1'b0, total_q} + coin_add;
        credit_ok  = 1'b0;
        bounce     = 3'b000;
        if (state_q == IDLE) begin
            refund_req = bus.return_coins && (total_q != 9'd0);
            sale       = !bus.return_coins && bus.buy &&
                         (bus.amount != 9'd0) && (total_q >= bus.amount);
            base       = sale ? (total_q - bus.amount) : total_q;
            credit_sum = {1'b0, base} + coin_add;
            if (credit_sum <= MAX_CREDIT_W) begin
                credit_ok = 1'b1;
            end else begin
                bounce = detect_vec;
            end
        end else begin
            // While paying out, every inserted coin goes straight back.
            bounce = detect_vec;
        end
    end

    vend_change_sel u_change_sel (
        .total       (total_q),
        .empty_5     (bus.empty_5),
        .empty_10    (bus.empty_10),
        .empty_25    (bus.empty_25),
        .bounce_mask (bounce),
        .coin        (sel)
    );

    // Next-state and registered-output logic for the controller FSM.
    always_comb begin
        state_d = state_q;
        total_d = total_q;
        ok_d    = 1'b0;
        disp    = 3'b000;
        case (state_q)
            IDLE: begin
                ok_d    = sale;
                total_d = credit_ok ? credit_sum[8:0] : base;
                if (refund_req) begin
                    state_d = REFUND;
                end else if (sale && (base != 9'd0)) begin
                    state_d = VEND_CHG;
                end
            end
            VEND_CHG, REFUND: begin
                if (total_q < C5) begin
                    // Sub-nickel remainder cannot be paid out; it is forfeited.
                    total_d = 9'd0;
                    state_d = IDLE;
                end else if (sel != COIN_NONE) begin
                    total_d = total_q - coin_value(sel);
                    case (sel)
                        COIN_C25: disp = 3'b100;
                        COIN_C10: disp = 3'b010;
                        default:  disp = 3'b001;
                    endcase
                    if (total_d == 9'd0) begin
                        state_d = IDLE;
                    end
                end
                // Otherwise stall: no eligible coin this cycle.
            end
            default: begin
                state_d = IDLE;
                total_d = 9'd0;
            end
        endcase

        ret25_d = bounce[2] | disp[2];
        ret10_d = bounce[1] | disp[1];
        ret5_d  = bounce[0] | disp[0];
        busy_d  = (state_d != IDLE);
    end

    // State and output registers; reset drops every pulse and discards credit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            total_q <= 9'd0;
            ok_q    <= 1'b0;
            ret5_q  <= 1'b0;
            ret10_q <= 1'b0;
            ret25_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            ok_q    <= ok_d;
            ret5_q  <= ret5_d;
            ret10_q <= ret10_d;
            ret25_q <= ret25_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ok        = ok_q;
    assign bus.return_5  = ret5_q;
    assign bus.return_10 = ret10_q;
    assign bus.return_25 = ret25_q;
    assign bus.total     = total_q;
    assign bus.busy      = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed scoreboard bench for vend_ctrl.
module tb_vend_ctrl;
    import vend_pkg::*;

    localparam int W = 14;   // {ok, r25, r10, r5, busy, total[8:0]}

    logic   clk;
    logic   rst;
    state_t dbg_state;

    vend_if vif();

    vend_ctrl #(.MAX_CREDIT(500)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (vif),
        .dbg_state (dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ev(input logic ok, input logic r25, input logic r10,
                                        input logic r5, input logic busy, input logic [8:0] tot);
        return {ok, r25, r10, r5, busy, tot};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One cycle of stimulus; pulse inputs are dropped after the edge.
    task automatic drive(input logic [2:0] coins, input logic b, input logic r, input logic [8:0] amt);
        vif.detect_25    = coins[2];
        vif.detect_10    = coins[1];
        vif.detect_5     = coins[0];
        vif.buy          = b;
        vif.return_coins = r;
        vif.amount       = amt;
        @(posedge clk);
        #1;
        vif.detect_25    = 1'b0;
        vif.detect_10    = 1'b0;
        vif.detect_5     = 1'b0;
        vif.buy          = 1'b0;
        vif.return_coins = 1'b0;
        vif.amount       = 9'd0;
    endtask

    // Wait (bounded) until the controller is idle and every expected event was seen.
    task automatic settle(input string name);
        int n;
        n = 0;
        while ((vif.busy || exp_q.size() != 0) && n < 80) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_busy"}, vif.busy, 0);
    endtask

    // Monitor: every output pulse is matched against the head of the expected queue.
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        if (rst && (vif.ok || vif.return_25 || vif.return_10 || vif.return_5)) begin
            act = {vif.ok, vif.return_25, vif.return_10, vif.return_5, vif.busy, vif.total};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual=%h expected=none", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL event actual=%h (total=%0d) expected=%h (total=%0d)",
                             act, act[8:0], exp, exp[8:0]);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst              = 1'b0;
        vif.detect_5     = 1'b0;
        vif.detect_10    = 1'b0;
        vif.detect_25    = 1'b0;
        vif.buy          = 1'b0;
        vif.return_coins = 1'b0;
        vif.amount       = 9'd0;
        vif.empty_5      = 1'b0;
        vif.empty_10     = 1'b0;
        vif.empty_25     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ok", vif.ok, 0);
        chk("rst_returns", {vif.return_25, vif.return_10, vif.return_5}, 0);
        chk("rst_total", vif.total, 0);
        chk("rst_busy", vif.busy, 0);
        chk("rst_state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b1;

        // Sale with change: 25+25+10, buy 35 -> 25 back.
        drive(3'b100, 0, 0, 0);
        drive(3'b100, 0, 0, 0);
        drive(3'b010, 0, 0, 0);
        chk("t1_total60", vif.total, 60);
        exp_q.push_back(ev(1, 0, 0, 0, 1, 25));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 0));
        drive(3'b000, 1, 0, 9'd35);
        chk("t1_busy_after_sale", vif.busy, 1);
        chk("t1_state_vend", dbg_state, VEND_CHG);
        settle("t1");
        chk("t1_total0", vif.total, 0);
        chk("t1_state_idle", dbg_state, IDLE);

        // Refund 45 with 25 tube empty: four 10s then a 5.
        drive(3'b100, 0, 0, 0);
        drive(3'b010, 0, 0, 0);
        drive(3'b010, 0, 0, 0);
        chk("t2_total45", vif.total, 45);
        vif.empty_25 = 1'b1;
        exp_q.push_back(ev(0, 0, 1, 0, 1, 35));
        exp_q.push_back(ev(0, 0, 1, 0, 1, 25));
        exp_q.push_back(ev(0, 0, 1, 0, 1, 15));
        exp_q.push_back(ev(0, 0, 1, 0, 1, 5));
        exp_q.push_back(ev(0, 0, 0, 1, 0, 0));
        drive(3'b000, 0, 1, 0);
        chk("t2_state_refund", dbg_state, REFUND);
        settle("t2");
        chk("t2_total0", vif.total, 0);
        vif.empty_25 = 1'b0;

        // Insufficient credit: buy 35 with 20 is ignored.
        drive(3'b010, 0, 0, 0);
        drive(3'b010, 0, 0, 0);
        drive(3'b000, 1, 0, 9'd35);
        chk("t3_total20", vif.total, 20);
        chk("t3_state_idle", dbg_state, IDLE);
        exp_q.push_back(ev(0, 0, 1, 0, 1, 10));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 0));
        drive(3'b000, 0, 1, 0);
        settle("t3");

        // Credit ceiling: 490 + 25 bounces, 490 + 10 reaches 500 exactly.
        for (int i = 0; i < 12; i++) drive(3'b111, 0, 0, 0);
        drive(3'b010, 0, 0, 0);
        chk("t4_total490", vif.total, 490);
        exp_q.push_back(ev(0, 1, 0, 0, 0, 490));
        drive(3'b100, 0, 0, 0);
        settle("t4_bounce25");
        chk("t4_total_kept", vif.total, 490);
        drive(3'b010, 0, 0, 0);
        chk("t4_total500", vif.total, 500);
        exp_q.push_back(ev(0, 1, 1, 1, 0, 500));
        drive(3'b111, 0, 0, 0);
        settle("t4_bounce_all");
        chk("t4_total500_kept", vif.total, 500);
        for (int k = 1; k <= 20; k++)
            exp_q.push_back(ev(0, 1, 0, 0, (k < 20), 9'(500 - 25 * k)));
        drive(3'b000, 0, 1, 0);
        settle("t4_refund500");

        // Stall with all tubes empty, then resume on nickels.
        vif.empty_5  = 1'b1;
        vif.empty_10 = 1'b1;
        vif.empty_25 = 1'b1;
        drive(3'b100, 0, 0, 0);
        drive(3'b100, 0, 0, 0);
        exp_q.push_back(ev(1, 0, 0, 0, 1, 15));
        drive(3'b000, 1, 0, 9'd35);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("t5_stall_busy", vif.busy, 1);
            chk("t5_stall_total", vif.total, 15);
        end
        exp_q.push_back(ev(0, 0, 0, 1, 1, 10));
        exp_q.push_back(ev(0, 0, 0, 1, 1, 5));
        exp_q.push_back(ev(0, 0, 0, 1, 0, 0));
        vif.empty_5 = 1'b0;
        settle("t5");
        chk("t5_state_idle", dbg_state, IDLE);
        vif.empty_10 = 1'b0;
        vif.empty_25 = 1'b0;

        // Odd price leaves 2 cents, which is forfeited without a pulse.
        drive(3'b100, 0, 0, 0);
        exp_q.push_back(ev(1, 0, 0, 0, 1, 2));
        drive(3'b000, 1, 0, 9'd23);
        settle("t6");
        chk("t6_total0", vif.total, 0);

        // Zero price ignored; coin with buy credited after the sale; refund beats buy.
        drive(3'b010, 0, 0, 0);
        drive(3'b000, 1, 0, 9'd0);
        chk("t7_zero_price_total", vif.total, 10);
        exp_q.push_back(ev(1, 0, 0, 0, 0, 25));
        drive(3'b100, 1, 0, 9'd10);
        chk("t7_same_cycle_total", vif.total, 25);
        chk("t7_same_cycle_state", dbg_state, IDLE);
        settle("t7_sale");
        exp_q.push_back(ev(0, 1, 0, 0, 0, 0));
        drive(3'b000, 1, 1, 9'd5);
        chk("t7_refund_priority", dbg_state, REFUND);
        settle("t7_refund");

        // Reset in the middle of a refund of 100.
        for (int i = 0; i < 4; i++) drive(3'b100, 0, 0, 0);
        chk("t8_total100", vif.total, 100);
        exp_q.push_back(ev(0, 1, 0, 0, 1, 75));
        exp_q.push_back(ev(0, 1, 0, 0, 1, 50));
        drive(3'b000, 0, 1, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t8_rst_returns", {vif.return_25, vif.return_10, vif.return_5}, 0);
        chk("t8_rst_ok", vif.ok, 0);
        chk("t8_rst_total", vif.total, 0);
        chk("t8_rst_busy", vif.busy, 0);
        chk("t8_pending", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t8_post_total", vif.total, 0);
        chk("t8_post_state", dbg_state, IDLE);
        chk("t8_post_busy", vif.busy, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
